alu_instr_sequencer: RTL

// - Fetches 41-bit instructions from program memory and splits them into ALU decode fields.
// - Drives the ALU dcd_req/dcd_ack handshake one instruction at a time.
// - Keeps the program counter and applies ALU jump requests (pc_jump_req/pc_jump_addr).
// - Sits between program ROM/RAM and the ALU. Adds a start/halt control, error flags and a watchdog.

---
 rtl/alu_isa_pkg.sv | 44 ++++
 rtl/alu_instr_sequencer_if.sv | 31 +++
 rtl/alu_instr_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_isa_pkg.sv
// Shared ALU ISA definitions: instruction layout, opcodes and sequencer state encoding.
package alu_isa_pkg;

  localparam int INSTR_W   = 41;
  localparam int PC_W      = 12;

  localparam int OPC_MSB   = 40;
  localparam int OPC_LSB   = 37;
  localparam int DST_MSB   = 36;
  localparam int DST_LSB   = 34;
  localparam int SRC1_MSB  = 33;
  localparam int SRC1_LSB  = 31;
  localparam int SRC2_MSB  = 30;
  localparam int SRC2_LSB  = 28;
  localparam int MEM_MSB   = 27;
  localparam int MEM_LSB   = 16;
  localparam int CONST_MSB = 15;
  localparam int CONST_LSB = 0;

  localparam logic [3:0] LOAD       = 4'h0;
  localparam logic [3:0] STORE      = 4'h1;
  localparam logic [3:0] ADD        = 4'h2;
  localparam logic [3:0] SUB        = 4'h3;
  localparam logic [3:0] LAND       = 4'h4;
  localparam logic [3:0] LOR        = 4'h5;
  localparam logic [3:0] LXOR       = 4'h6;
  localparam logic [3:0] SHL        = 4'h7;
  localparam logic [3:0] JUMP       = 4'h8;
  localparam logic [3:0] JUMP_IF_EQ = 4'h9;
  localparam logic [3:0] HALT       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } seq_state_e;

  // Opcodes 4'hA..4'hE are reserved and must not reach the ALU
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Program-memory read port and ALU decode/jump handshake bundled for the sequencer.
interface alu_instr_sequencer_if;
  import alu_isa_pkg::*;

  logic               prog_mem_cen;
  logic [PC_W-1:0]    prog_mem_addr;
  logic [INSTR_W-1:0] prog_mem_rd_data;
  logic               dcd_req;
  logic [3:0]         dcd_opcode;
  logic [2:0]         dcd_dst_reg_addr;
  logic [2:0]         dcd_src_reg_1_addr;
  logic [2:0]         dcd_src_reg_2_addr;
  logic [11:0]        dcd_mem_addr;
  logic [15:0]        dcd_const;
  logic               dcd_ack;
  logic               pc_jump_req;
  logic [PC_W-1:0]    pc_jump_addr;

  modport master (
    output prog_mem_cen, prog_mem_addr, dcd_req, dcd_opcode, dcd_dst_reg_addr,
           dcd_src_reg_1_addr, dcd_src_reg_2_addr, dcd_mem_addr, dcd_const,
    input  prog_mem_rd_data, dcd_ack, pc_jump_req, pc_jump_addr
  );

  modport slave (
    input  prog_mem_cen, prog_mem_addr, dcd_req, dcd_opcode, dcd_dst_reg_addr,
           dcd_src_reg_1_addr, dcd_src_reg_2_addr, dcd_mem_addr, dcd_const,
    output prog_mem_rd_data, dcd_ack, pc_jump_req, pc_jump_addr
  );

endinterface

// File: rtl/alu_instr_sequencer.sv
// Instruction sequencer: fetches instructions, hands decode fields to the ALU one at a time,
// and owns the pc, pending jumps, error flags, retired count and the request watchdog.
module alu_instr_sequencer
  import alu_isa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PC_W-1:0]       start_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      instr_count,
  alu_instr_sequencer_if.master bus
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e         state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [PC_W-1:0]    jump_addr_r, jump_addr_s;
  logic [PC_W-1:0]    mem_addr_r, mem_addr_s;
  logic               jump_pend_r, jump_pend_s;
  logic [WD_W-1:0]    wd_r, wd_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_ill_r, err_ill_s;
  logic               err_to_r, err_to_s;
  logic               cen_r, cen_s;
  logic               req_r, req_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic [3:0]         rd_op_s;
  logic               jump_take_s;
  logic [PC_W-1:0]    jump_tgt_s;

  assign rd_op_s     = bus.prog_mem_rd_data[OPC_MSB:OPC_LSB];
  // A jump pulse coinciding with the ack wins over an older pending target
  assign jump_take_s = bus.pc_jump_req | jump_pend_r;
  assign jump_tgt_s  = bus.pc_jump_req ? bus.pc_jump_addr : jump_addr_r;

  // Next-state and next-register computation for the sequencer
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    jump_addr_s = jump_addr_r;
    mem_addr_s  = mem_addr_r;
    jump_pend_s = jump_pend_r;
    wd_s        = wd_r;
    cnt_s       = cnt_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_ill_s   = err_ill_r;
    err_to_s    = err_to_r;
    cen_s       = 1'b0;
    req_s       = req_r;
    instr_s     = instr_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pc_s        = start_pc;
          mem_addr_s  = start_pc;
          cen_s       = 1'b1;
          err_ill_s   = 1'b0;
          err_to_s    = 1'b0;
          cnt_s       = {CNT_W{1'b0}};
          jump_pend_s = 1'b0;
          busy_s      = 1'b1;
          state_s     = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        instr_s = bus.prog_mem_rd_data;
        if (rd_op_s == HALT) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (is_illegal_op(rd_op_s)) begin
          err_ill_s  = 1'b1;
          pc_s       = pc_r + 12'd1;
          mem_addr_s = pc_r + 12'd1;
          cen_s      = 1'b1;
          state_s    = ST_FETCH;
        end else begin
          req_s   = 1'b1;
          wd_s    = {WD_W{1'b0}};
          state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.dcd_ack) begin
          req_s       = 1'b0;
          pc_s        = jump_take_s ? jump_tgt_s : pc_r + 12'd1;
          mem_addr_s  = pc_s;
          cen_s       = 1'b1;
          jump_pend_s = 1'b0;
          cnt_s       = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
          state_s     = ST_FETCH;
        end else if (wd_r == WD_LAST) begin
          req_s       = 1'b0;
          err_to_s    = 1'b1;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          jump_pend_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          wd_s = wd_r + WD_W'(1);
          if (bus.pc_jump_req) begin
            jump_pend_s = 1'b1;
            jump_addr_s = bus.pc_jump_addr;
          end else begin
            jump_pend_s = jump_pend_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= {PC_W{1'b0}};
      jump_addr_r <= {PC_W{1'b0}};
      mem_addr_r  <= {PC_W{1'b0}};
      jump_pend_r <= 1'b0;
      wd_r        <= {WD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_ill_r   <= 1'b0;
      err_to_r    <= 1'b0;
      cen_r       <= 1'b0;
      req_r       <= 1'b0;
      instr_r     <= {INSTR_W{1'b0}};
    end else begin
      pc_r        <= pc_s;
      jump_addr_r <= jump_addr_s;
      mem_addr_r  <= mem_addr_s;
      jump_pend_r <= jump_pend_s;
      wd_r        <= wd_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_ill_r   <= err_ill_s;
      err_to_r    <= err_to_s;
      cen_r       <= cen_s;
      req_r       <= req_s;
      instr_r     <= instr_s;
    end
  end

  assign busy                   = busy_r;
  assign done                   = done_r;
  assign err_illegal            = err_ill_r;
  assign err_timeout            = err_to_r;
  assign instr_count            = cnt_r;
  assign bus.prog_mem_cen       = cen_r;
  assign bus.prog_mem_addr      = mem_addr_r;
  assign bus.dcd_req            = req_r;
  assign bus.dcd_opcode         = instr_r[OPC_MSB:OPC_LSB];
  assign bus.dcd_dst_reg_addr   = instr_r[DST_MSB:DST_LSB];
  assign bus.dcd_src_reg_1_addr = instr_r[SRC1_MSB:SRC1_LSB];
  assign bus.dcd_src_reg_2_addr = instr_r[SRC2_MSB:SRC2_LSB];
  assign bus.dcd_mem_addr       = instr_r[MEM_MSB:MEM_LSB];
  assign bus.dcd_const          = instr_r[CONST_MSB:CONST_LSB];

endmodule
